// File: rtl/req_arbiter_8.sv
// req_arbiter_8: eight-requester arbiter with fixed-priority or round-robin
// winner selection, grant-until-release ownership and an optional hold
// timeout that preempts an owner once other requesters are waiting.
module req_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       rr_mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // Timeout is armed once the counter reaches this value; it also saturates here.
  localparam logic             HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [7:0]       r_gnt;
  logic [2:0]       r_gnt_idx;
  logic             r_gnt_valid;
  logic             r_preempt;
  logic [2:0]       r_last_idx;
  logic [CNT_W-1:0] r_hold_cnt;

  state_t           w_state_nxt;
  logic [7:0]       w_gnt_nxt;
  logic [2:0]       w_gnt_idx_nxt;
  logic             w_gnt_valid_nxt;
  logic             w_preempt_nxt;
  logic [2:0]       w_last_idx_nxt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;

  logic [7:0]       w_owner_oh;
  logic [7:0]       w_others;
  logic [7:0]       w_cand;
  logic             w_release;
  logic             w_timeout;
  logic             w_arb;
  logic             w_win_found;
  logic [2:0]       w_win_idx;

  // Arbitration event decode; a release takes precedence over a coincident timeout.
  assign w_owner_oh = 8'b1 << r_gnt_idx;
  assign w_others   = req & ~w_owner_oh;
  assign w_release  = (r_state == ST_OWN) && !req[r_gnt_idx];
  assign w_timeout  = (r_state == ST_OWN) && HOLD_EN && (r_hold_cnt == HOLD_LAST) &&
                      (|w_others) && !w_release;
  assign w_cand     = (r_state == ST_IDLE) ? req : w_others;
  assign w_arb      = ((r_state == ST_IDLE) && (|req)) || w_release || w_timeout;

  // Winner pick: highest set bit, or descending search from last_idx-1 in round-robin.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = 3'd0;
    if (!rr_mode) begin
      for (int i = 0; i < 8; i++) begin
        if (w_cand[i]) begin
          w_win_found = 1'b1;
          w_win_idx   = 3'(i);
        end
      end
    end else begin
      // Walk from the farthest search position to the nearest so the nearest hit wins.
      for (int j = 7; j >= 0; j--) begin
        if (w_cand[r_last_idx - 3'(j + 1)]) begin
          w_win_found = 1'b1;
          w_win_idx   = r_last_idx - 3'(j + 1);
        end
      end
    end
  end

  // State register plus registered outputs and bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
      r_last_idx  <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_preempt   <= w_preempt_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  // Next-state: an arbitration event lands in OWN if anyone is eligible, else IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (w_arb) begin
      w_state_nxt = w_win_found ? ST_OWN : ST_IDLE;
    end
  end

  // Next output values: new grant on an event, otherwise hold and count.
  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_preempt_nxt   = 1'b0;
    w_last_idx_nxt  = r_last_idx;
    w_hold_cnt_nxt  = r_hold_cnt;
    if (w_arb) begin
      w_hold_cnt_nxt = '0;
      if (w_win_found) begin
        w_gnt_nxt       = 8'b1 << w_win_idx;
        w_gnt_idx_nxt   = w_win_idx;
        w_gnt_valid_nxt = 1'b1;
        w_last_idx_nxt  = w_win_idx;
        w_preempt_nxt   = w_timeout;
      end else begin
        w_gnt_nxt       = '0;
        w_gnt_idx_nxt   = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    end else if ((r_state == ST_OWN) && HOLD_EN && (r_hold_cnt != HOLD_LAST)) begin
      w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_req_arbiter_8.sv
// Directed bench for req_arbiter_8 with MAX_HOLD = 4.
`timescale 1ns/1ps
module tb_req_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rr_mode;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_cmp;
  int n_err;

  req_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .rr_mode  (rr_mode),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx, input logic pre);
    logic [7:0] oh;
    oh = 8'b1 << idx;
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(oh));
    check_eq({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'd1);
    check_eq({tag, ".preempt"}, 32'(preempt), 32'(pre));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".gnt"}, 32'(gnt), 32'd0);
    check_eq({tag, ".idx"}, 32'(gnt_idx), 32'd0);
    check_eq({tag, ".valid"}, 32'(gnt_valid), 32'd0);
    check_eq({tag, ".preempt"}, 32'(preempt), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] cur;
    logic [2:0] nxt;
    n_cmp   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    req     = 8'h00;
    rr_mode = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst_n = 1'b1;

    // Fixed priority from idle: highest index of 0010_0100 wins.
    req = 8'b0010_0100;
    tick();
    check_grant("fix_first", 3'd5, 1'b0);

    // Owner 5 releases with 2 pending: hand over without preempt.
    req = 8'b0000_0100;
    tick();
    check_grant("fix_release", 3'd2, 1'b0);
    req = 8'h00;
    tick();
    check_idle("fix_drop");

    // Round-robin with all requesting; each owner drops once after its grant.
    do_reset();
    rr_mode = 1'b1;
    req = 8'hFF;
    tick();
    check_grant("rr_first", 3'd7, 1'b0);
    cur = 3'd7;
    for (int k = 0; k < 8; k++) begin
      nxt = cur - 3'd1;
      req = 8'hFF & ~(8'b1 << cur);
      tick();
      check_grant($sformatf("rr_step%0d", k), nxt, 1'b0);
      req = 8'hFF;
      tick();
      check_eq($sformatf("rr_hold%0d", k), 32'(gnt_idx), 32'(nxt));
      cur = nxt;
    end
    req = 8'h00;
    tick();
    check_idle("rr_drop");

    // Lone owner keeps the grant past MAX_HOLD until contention appears.
    rr_mode = 1'b0;
    req = 8'h40;
    tick();
    check_grant("hog_first", 3'd6, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq($sformatf("hog_keep%0d", k), 32'(gnt_idx), 32'd6);
    end
    req = 8'h42;
    tick();
    check_grant("hog_preempt", 3'd1, 1'b1);
    tick();
    check_grant("hog_after", 3'd1, 1'b0);
    req = 8'h00;
    tick();
    check_idle("hog_drop");

    // Round-robin timeout ping-pong between 7 and 0 every 4 cycles.
    do_reset();
    rr_mode = 1'b1;
    req = 8'b1000_0001;
    tick();
    check_grant("pp_first", 3'd7, 1'b0);
    cur = 3'd7;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check_grant($sformatf("pp_hold%0d_%0d", s, k), cur, 1'b0);
      end
      nxt = (cur == 3'd7) ? 3'd0 : 3'd7;
      tick();
      check_grant($sformatf("pp_switch%0d", s), nxt, 1'b1);
      cur = nxt;
    end

    // Asynchronous reset mid-grant clears outputs without waiting for an edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    req     = 8'h08;
    rr_mode = 1'b1;
    #2;
    rst_n = 1'b1;
    tick();
    check_grant("post_rst", 3'd3, 1'b0);
    req = 8'h00;
    tick();
    check_idle("post_rst_drop");

    // Release coinciding with an armed timeout counts as a release.
    rr_mode = 1'b0;
    req = 8'h30;
    tick();
    check_grant("coin_first", 3'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_grant($sformatf("coin_hold%0d", k), 3'd5, 1'b0);
    end
    req = 8'h10;
    tick();
    check_grant("coin_release", 3'd4, 1'b0);
    req = 8'h00;
    tick();
    check_idle("coin_drop");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/req_arbiter_8.md
Name: req_arbiter_8

Overview:
- Eight-requester arbiter that shares one downstream resource. Winner selection reuses the 8-to-3 priority-encoding rule: the highest index wins.
- Supports fixed-priority and round-robin modes.
- Grants are held until the owner releases. An optional hold timeout preempts a hogging owner.
- Sits between requesting agents and the shared datapath. The grant index drives the resource's select input.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles before preemption is allowed. 0 disables preemption. Legal range 0..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request vector; bit i held high while requester i wants the resource
- rr_mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- gnt  out  8  one-hot grant, registered
- gnt_idx  out  3  binary index of the granted requester; 0 when gnt_valid = 0
- gnt_valid  out  1  high when any grant is active
- preempt  out  1  one-cycle pulse on the edge where a grant is revoked by timeout

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, preempt = 0.
  - hold_cnt = 0, last_idx = 0, state = IDLE.
  - Deassertion of reset is synchronous to clk by the system. The first arbitration occurs on the first rising edge with rst_n high.
- States: IDLE (no owner), OWN (owner = gnt_idx).
- Arbitration event happens at a rising edge when any of the following holds:
  - (a) state IDLE and req != 0
  - (b) state OWN and req[owner] == 0 (release)
  - (c) state OWN, MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and (req & ~onehot(owner)) != 0 (timeout)
- Candidate vector:
  - Case (a): cand = req.
  - Cases (b) and (c): cand = req & ~onehot(owner). The owner is never re-granted on the same edge it loses the grant.
- Winner selection:
  - rr_mode = 0: highest set bit of cand.
  - rr_mode = 1: search descending starting at (last_idx-1) mod 8, wrapping 0 -> 7. The first set bit wins. last_idx itself is checked last.
  - After reset, last_idx = 0, so round-robin's first search starts at 7 and matches fixed priority.
  - rr_mode is sampled only at arbitration events. Changing it mid-grant has no effect on the current owner.
- Outcome of an arbitration event:
  - cand != 0: winner w. gnt = onehot(w), gnt_idx = w, gnt_valid = 1, last_idx = w, hold_cnt = 0, state = OWN.
  - cand == 0: gnt = 0, gnt_idx = 0, gnt_valid = 0, state = IDLE. last_idx keeps its value.
- Latency: req rising in cycle N, with the arbiter idle, gives gnt visible in cycle N+1.
- Release: owner drops req in cycle M. gnt moves to the next winner (or drops to zero) in cycle M+1, with no idle gap.
- Hold counter:
  - Increments each cycle in OWN with no arbitration event.
  - Saturates at MAX_HOLD-1 when no other request is pending. The owner keeps the grant indefinitely until contention appears.
  - Timeout fires on the first edge with contention after saturation.
- preempt:
  - Asserted for exactly the cycle following a type (c) event.
  - Never asserted for release events (b).
- Simultaneous events: if release and timeout coincide, treat as release (preempt = 0).
- gnt is always one-hot or zero. gnt_idx is consistent with gnt every cycle.
- A grant is never issued to a requester whose req was low at the arbitration edge.

Test Plan:
- Fixed mode, idle; req = 8'b0010_0100 at cycle 0 -> cycle 1: gnt = 8'b0010_0000, gnt_idx = 5, gnt_valid = 1.
- Fixed mode; owner 5 drops req while req[2] = 1 -> next cycle gnt = 8'b0000_0100, gnt_idx = 2, preempt = 0. Then req = 0 -> next cycle gnt_valid = 0, gnt_idx = 0.
- Round-robin; req = 8'hFF held; each owner drops req for one cycle after being granted, then re-raises -> grant sequence 7,6,5,4,3,2,1,0,7.
- MAX_HOLD = 4; req[6] held alone for 10 cycles -> gnt stays on 6. Raise req[1] -> within 1 cycle gnt = idx 1 and preempt = 1 for one cycle.
- MAX_HOLD = 4, round-robin, req = 8'b1000_0001 held -> grant alternates 7,0,7,0 every 4 cycles with a preempt pulse at each switch.
- rst_n pulled low mid-grant, asynchronously between edges -> gnt, gnt_idx, gnt_valid, preempt are 0 immediately. After release with req = 8'h08 in round-robin mode -> gnt_idx = 3 on the first edge.
